// File: rtl/zrl_packer_if.sv
// Codeword-in / packed-word-out handshake bundle for zrl_packer.
interface zrl_packer_if;
   logic [67:0] data_i;
   logic [6:0]  size_i;
   logic        sop_i;
   logic        eop_i;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        sop_o;
   logic        eop_o;
   logic [6:0]  last_bits_o;

   modport slave (
      input  data_i, size_i, sop_i, eop_i, valid_i, ready_i,
      output ready_o, data_o, valid_o, sop_o, eop_o, last_bits_o
   );

   modport master (
      output data_i, size_i, sop_i, eop_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o, sop_o, eop_o, last_bits_o
   );
endinterface

// File: rtl/zrl_packer.sv
// Packs variable-length MSB-aligned ZRL codewords into a 64-bit MSB-first word stream.
// Optional ZRL_PACKER_STAT_EN adds a per-packet codeword bit counter.
module zrl_packer (
   input  logic         clk,
   input  logic         rst_n,
   zrl_packer_if.slave  bus
`ifdef ZRL_PACKER_STAT_EN
   ,
   output logic [15:0]  pkt_bits_o,
   output logic         pkt_bits_vld_o
`endif
);

   typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} mode_e;

   mode_e         mode_q, mode_d;
   logic [131:0]  acc_q;
   logic [7:0]    cnt_q;
   logic          sop_pend_q;
   logic          in_pkt_q;
   logic          accept, emit;
   logic [67:0]   cw_mask;
   logic [131:0]  cw_place;

   assign accept = bus.valid_i & bus.ready_o;
   assign emit   = bus.valid_o & bus.ready_i;

   // Keep only the top size_i bits, then drop them just below the bits already held.
   assign cw_mask  = bus.data_i & ~({68{1'b1}} >> bus.size_i);
   assign cw_place = {cw_mask, 64'b0} >> cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode_q <= FILL;
      else        mode_q <= mode_d;
   end

   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         FILL:    if (accept && bus.eop_i) mode_d = FLUSH;
         FLUSH:   if (emit && cnt_q <= 8'd64) mode_d = FILL;
         default: mode_d = FILL;
      endcase
   end

   always_comb begin
      bus.ready_o     = (mode_q == FILL) && (cnt_q < 8'd64);
      bus.valid_o     = ((mode_q == FILL) && (cnt_q >= 8'd64)) ||
                        ((mode_q == FLUSH) && (cnt_q != 8'd0));
      bus.data_o      = acc_q[131:68];
      bus.sop_o       = bus.valid_o & sop_pend_q;
      bus.eop_o       = (mode_q == FLUSH) && (cnt_q <= 8'd64) && bus.valid_o;
      bus.last_bits_o = bus.eop_o ? cnt_q[6:0] : 7'd64;
   end

   // Bits below cnt are always zero, so OR-ing in the new codeword is enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         sop_pend_q <= 1'b0;
         in_pkt_q   <= 1'b0;
      end else if (accept) begin
         acc_q    <= acc_q | cw_place;
         cnt_q    <= cnt_q + {1'b0, bus.size_i};
         in_pkt_q <= ~bus.eop_i;
         if (bus.sop_i && !in_pkt_q) sop_pend_q <= 1'b1;
      end else if (emit) begin
         acc_q      <= {acc_q[67:0], 64'b0};
         cnt_q      <= (cnt_q > 8'd64) ? cnt_q - 8'd64 : 8'd0;
         sop_pend_q <= 1'b0;
      end
   end

`ifdef ZRL_PACKER_STAT_EN
   logic [15:0] bits_q;
   logic [16:0] bits_sum;

   assign bits_sum       = {1'b0, bits_q} + {10'b0, bus.size_i};
   assign pkt_bits_o     = bits_q;
   assign pkt_bits_vld_o = emit & bus.eop_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              bits_q <= '0;
      else if (accept)         bits_q <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
      else if (pkt_bits_vld_o) bits_q <= '0;
   end
`endif

endmodule
